// File: rtl/team_06_sram_responder_if.sv
// Client request and Wishbone-classic signal bundle for the team_06 SRAM responder.
// The master modport is the responder; the slave modport is the client plus SRAM side.
interface team_06_sram_responder_if;
  logic        read;
  logic        write;
  logic [31:0] addressIn;
  logic [31:0] busAudioWrite;
  logic [3:0]  select;
  logic        busySRAM;
  logic [31:0] busAudioRead;
  logic        errSticky;
  logic        clrErr;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I;

  modport master (
    input  read, write, addressIn, busAudioWrite, select, clrErr, DAT_I, ACK_I,
    output busySRAM, busAudioRead, errSticky, ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O
  );

  modport slave (
    output read, write, addressIn, busAudioWrite, select, clrErr, DAT_I, ACK_I,
    input  busySRAM, busAudioRead, errSticky, ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O
  );
endinterface

// File: rtl/team_06_sram_responder.sv
// Serves single-word client read/write requests as Wishbone-classic cycles into the
// SRAM window, with an address-window check and a bounded wait for ACK_I.
module team_06_sram_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'h3300_0000,
  parameter int unsigned WINDOW_BYTES   = 8192,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  team_06_sram_responder_if.master  bus
);

  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] LAST_OFF = DATA_W'(WINDOW_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              we_q;

  logic [DATA_W-1:0] rd_q;
  logic              err_q;
  logic [DATA_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [SEL_W-1:0]  sel_o;
  logic              we_o;
  logic              cyc_o;
  logic              stb_o;

  logic req, start, start_ok, start_err, ack_hit, expire;
  logic busy, err_set, rd_err, rd_dat;

  // Word-aligned and inside [BASE_ADDR, BASE_ADDR + WINDOW_BYTES - 4].
  function automatic logic addr_ok(input logic [DATA_W-1:0] a);
    logic [DATA_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off <= LAST_OFF) && (a[1:0] == 2'b00);
  endfunction

  always_comb begin
    req       = bus.read | bus.write;
    start     = (state == IDLE) && req;
    start_ok  = start && addr_ok(bus.addressIn);
    start_err = start && !addr_ok(bus.addressIn);
    ack_hit   = (state == BUS) && bus.ACK_I;
    expire    = (state == BUS) && !bus.ACK_I && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = BUS;
        end else if (start_err) begin
          state_nxt = DONE;
        end
      end
      BUS: begin
        if (ack_hit || expire) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy must show in the same cycle the request is raised; it is forced low while in reset.
  always_comb begin
    busy    = 1'b0;
    err_set = 1'b0;
    rd_err  = 1'b0;
    rd_dat  = 1'b0;
    case (state)
      IDLE: begin
        busy    = req;
        err_set = start_err;
        rd_err  = start_err && !bus.write;
      end
      BUS: begin
        busy    = 1'b1;
        err_set = expire;
        rd_err  = expire && !we_q;
        rd_dat  = ack_hit && !we_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    busy = busy & rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      rd_q  <= '0;
      err_q <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      sel_o <= '0;
      we_o  <= 1'b0;
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
    end else begin
      if (start) begin
        adr_q <= bus.addressIn;
        dat_q <= bus.busAudioWrite;
        sel_q <= bus.select;
        we_q  <= bus.write;
      end

      if (start_ok) begin
        cnt   <= '0;
        adr_o <= bus.addressIn;
        dat_o <= bus.busAudioWrite;
        sel_o <= bus.select;
        we_o  <= bus.write;
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
      end else if (state == BUS) begin
        if (ack_hit || expire) begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
          sel_o <= '0;
        end else begin
          cnt   <= cnt + 1'b1;
          adr_o <= adr_q;
          dat_o <= dat_q;
          sel_o <= sel_q;
          we_o  <= we_q;
        end
      end

      if (rd_dat) begin
        rd_q <= bus.DAT_I;
      end else if (rd_err) begin
        rd_q <= ERR_DATA;
      end

      // A new error in the same cycle as a clear leaves the flag set.
      if (err_set) begin
        err_q <= 1'b1;
      end else if (bus.clrErr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.busySRAM     = busy;
  assign bus.busAudioRead = rd_q;
  assign bus.errSticky    = err_q;
  assign bus.ADR_O        = adr_o;
  assign bus.DAT_O        = dat_o;
  assign bus.SEL_O        = sel_o;
  assign bus.WE_O         = we_o;
  assign bus.CYC_O        = cyc_o;
  assign bus.STB_O        = stb_o;

endmodule

// File: doc/team_06_sram_responder.md
Name: team_06_sram_responder

Overview:
- Responder end of the team_06 audio-buffer request interface. Serves single-word read/write requests from the audio read/write client and executes them as Wishbone-classic master cycles toward the SRAM window at 0x3300_0000.
- Drives busySRAM and busAudioRead back to the client.
- Adds an address-window check and a bus timeout, so a stalled or misaddressed request can never hang the client.

Parameters:
- BASE_ADDR, 32'h3300_0000, first byte address of the SRAM window.
- WINDOW_BYTES, 8192, window size in bytes; legal word addresses are BASE_ADDR to BASE_ADDR+WINDOW_BYTES-4.
- TIMEOUT_CYCLES, 64, maximum cycles waiting for ACK_I before the access is aborted.
- ERR_DATA, 32'hDEAD_BEEF, value returned on a failed read.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- read  input  1  client read request, level, held until client sees busySRAM low
- write  input  1  client write request, level, same rule as read
- addressIn  input  32  client byte address, word-aligned
- busAudioWrite  input  32  client write data
- select  input  4  client byte enables
- busySRAM  output  1  responder busy
- busAudioRead  output  32  read data, registered
- errSticky  output  1  set on any timeout or out-of-window request
- clrErr  input  1  synchronous clear of errSticky
- ADR_O  output  32  Wishbone address
- DAT_O  output  32  Wishbone write data
- DAT_I  input  32  Wishbone read data
- SEL_O  output  4  Wishbone byte select
- WE_O  output  1  Wishbone write enable
- STB_O  output  1  Wishbone strobe
- CYC_O  output  1  Wishbone cycle
- ACK_I  input  1  Wishbone acknowledge

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busAudioRead=0, errSticky=0.
  - All Wishbone outputs=0. Latched address, data and select registers=0.
- State machine states: IDLE, BUS, DONE.
- IDLE:
  - If write=1, or read=1, or both: latch addressIn, busAudioWrite and select, and set a latched WE. Write has priority when both are high.
  - If the latched address is outside the window, or addressIn[1:0]!=0: go to DONE without a bus cycle. Set errSticky. A read loads busAudioRead=ERR_DATA.
  - Otherwise go to BUS and clear the timeout counter.
- busySRAM is combinational:
  - 1 when state==BUS.
  - 1 when state==IDLE and (read|write).
  - 0 otherwise.
  - Rationale: the client checks busy in the cycle after raising its request, so busy must be visible in that same cycle.
- BUS:
  - CYC_O=STB_O=1. ADR_O, DAT_O, SEL_O and WE_O come from the latched values. All Wishbone outputs are registered and change only on the IDLE->BUS and BUS->DONE edges.
  - On ACK_I=1: drop CYC_O and STB_O next cycle and go to DONE. A read captures DAT_I into busAudioRead on that edge.
  - Timeout counter increments each BUS cycle without ACK. When it reaches TIMEOUT_CYCLES-1 without ACK: abort (CYC/STB low), set errSticky, a read loads ERR_DATA, go to DONE.
  - ACK_I arriving in the same cycle as the timeout limit counts as a success.
- DONE:
  - Exactly one cycle. busySRAM=0, busAudioRead stable.
  - read and write are ignored in this cycle, because the client's request register is still high here.
  - Always returns to IDLE.
- Latency: a read with zero-wait ACK (ACK_I in the first BUS cycle) has busy high for 2 cycles; busAudioRead is valid in the DONE cycle and held until the next read completes.
- busAudioRead is unchanged by writes.
- errSticky: clrErr=1 clears it. If a new error occurs in the same cycle, set wins.
- ACK_I while not in BUS is ignored.
- No internal byte-lane manipulation: SEL_O is a pass-through of the latched select.

Test Plan:
- Read, ACK after 2 wait cycles, addressIn=0x3300_0010, DAT_I=0xA1B2C3D4:
  - ADR_O=0x3300_0010, WE_O=0, busy high for 4 cycles.
  - busAudioRead=0xA1B2C3D4 in DONE, errSticky=0.
- Write, busAudioWrite=0x11223344, select=4'hF, addr=0x3300_1FFC, ACK immediately:
  - WE_O=1, DAT_O=0x11223344, SEL_O=F for 1 cycle.
  - busy low in DONE, busAudioRead unchanged.
- read and write both asserted:
  - Write cycle issued.
  - After DONE and a return to IDLE with read still high, a second (read) cycle starts.
- addressIn=0x3300_2000 (outside window), read:
  - No CYC_O pulse, busAudioRead=0xDEADBEEF, errSticky=1.
  - clrErr pulse -> errSticky=0.
- Read with ACK_I never asserted:
  - CYC_O high for exactly 64 cycles, then busAudioRead=0xDEADBEEF, errSticky=1.
  - Next request served normally.
- rst pulled low mid-BUS:
  - CYC_O, STB_O and busySRAM drop immediately; state=IDLE; busAudioRead=0 after release.
